// File: rtl/gpio_cfg_decoder.sv
// gpio_cfg_decoder: decodes bit-banged GPIO serial clocks into channel select, cycle count and per-channel shift strobes
module gpio_cfg_decoder #(
  parameter int NUM_CH  = 16,
  parameter int CYCLE_W = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         gpio_in,
  output logic [NUM_CH-1:0]  sel_reg,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               cfg_sdata,
  output logic [NUM_CH-1:0]  mask_shift_en,
  output logic [NUM_CH-1:0]  mux_shift_en,
  output logic               sel_err
);
  logic [4:0] s1, s2;
  logic [4:1] s3, rise;
  logic [1:0] arm;
  logic       sdata;
  logic       unused_gpio;
  assign unused_gpio = ^gpio_in[7:5];
  assign sdata = s2[0];
  // edges are ignored until arm saturates so a clock bit high at reset release is not seen as a rise
  assign rise = s2[4:1] & ~s3 & {4{&arm}};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= '0;
      s2            <= '0;
      s3            <= '0;
      arm           <= '0;
      sel_reg       <= '0;
      cycle_count   <= '0;
      cfg_sdata     <= 1'b0;
      mask_shift_en <= '0;
      mux_shift_en  <= '0;
      sel_err       <= 1'b1;
    end else begin
      s1            <= gpio_in[4:0];
      s2            <= s1;
      s3            <= s2[4:1];
      arm           <= arm + {1'b0, ~&arm};
      sel_reg       <= rise[2] ? {sel_reg[NUM_CH-2:0], sdata} : sel_reg;
      cycle_count   <= rise[3] ? {cycle_count[CYCLE_W-2:0], sdata} : cycle_count;
      cfg_sdata     <= (rise[1] | rise[4]) ? sdata : cfg_sdata;
      mask_shift_en <= rise[1] ? sel_reg : '0;
      mux_shift_en  <= rise[4] ? sel_reg : '0;
      sel_err       <= !$onehot(sel_reg);
    end
  end
endmodule

// File: tb/tb_gpio_cfg_decoder.sv
// tb_gpio_cfg_decoder: directed vectors for gpio_cfg_decoder with hand-computed expectations
module tb_gpio_cfg_decoder;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   gpio_in;
  logic [15:0]  sel_reg;
  logic [255:0] cycle_count;
  logic         cfg_sdata;
  logic [15:0]  mask_shift_en;
  logic [15:0]  mux_shift_en;
  logic         sel_err;
  int errors = 0;
  int checks = 0;
  int mask_cnt = 0, mux_cnt = 0;
  logic [15:0] mask_val = '0, mux_val = '0;
  logic [255:0] exp_cc;

  gpio_cfg_decoder dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .sel_reg(sel_reg),
    .cycle_count(cycle_count), .cfg_sdata(cfg_sdata), .mask_shift_en(mask_shift_en),
    .mux_shift_en(mux_shift_en), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // strobe monitor: counts cycles each strobe bus is non-zero and keeps the last value
  always @(negedge clk) begin
    if (mask_shift_en != '0) begin
      mask_cnt <= mask_cnt + 1;
      mask_val <= mask_shift_en;
    end
    if (mux_shift_en != '0) begin
      mux_cnt <= mux_cnt + 1;
      mux_val <= mux_shift_en;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    mask_cnt = 0;
    mux_cnt  = 0;
    mask_val = '0;
    mux_val  = '0;
  endtask

  task automatic pulse(input int b, input logic d);
    gpio_in[0] = d;
    cyc(3);
    gpio_in[b] = 1'b1;
    cyc(4);
    gpio_in[b] = 1'b0;
    cyc(4);
  endtask

  task automatic shift_sel(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) pulse(2, v[i]);
  endtask

  initial begin
    rst_n   = 1'b0;
    gpio_in = 8'h00;
    cyc(3);
    chk("rst_sel", sel_reg, 0);
    chk("rst_err", sel_err, 1);
    chk("rst_cc", cycle_count, 0);
    chk("rst_strobes", {mask_shift_en, mux_shift_en, cfg_sdata}, 0);
    rst_n = 1'b1;
    cyc(5);
    shift_sel(16'h0004);
    chk("sel_0004", sel_reg, 16'h0004);
    chk("sel_err_0004", sel_err, 0);
    clr_mon();
    pulse(1, 1'b1);
    chk("mask_cnt", mask_cnt, 1);
    chk("mask_val", mask_val, 16'h0004);
    chk("mask_sdata", cfg_sdata, 1);
    chk("mask_no_mux", mux_cnt, 0);
    for (int i = 0; i < 256; i++) pulse(3, i == 0);
    exp_cc = '0;
    exp_cc[255] = 1'b1;
    chk("cc_1sh255", cycle_count, exp_cc);
    chk("cc_sel_kept", sel_reg, 16'h0004);
    clr_mon();
    pulse(4, 1'b0);
    chk("mux_cnt", mux_cnt, 1);
    chk("mux_val", mux_val, 16'h0004);
    chk("mux_sdata", cfg_sdata, 0);
    chk("mux_no_mask", mask_cnt, 0);
    pulse(0, 1'b1);
    chk("sdata_hold", cfg_sdata, 0);
    shift_sel(16'h0001);
    chk("sel_0001", sel_reg, 16'h0001);
    clr_mon();
    gpio_in[0] = 1'b0;
    cyc(3);
    gpio_in[4] = 1'b1;
    gpio_in[2] = 1'b1;
    cyc(4);
    gpio_in[4] = 1'b0;
    gpio_in[2] = 1'b0;
    cyc(4);
    chk("coinc_mux_val", mux_val, 16'h0001);
    chk("coinc_mux_cnt", mux_cnt, 1);
    chk("coinc_sel", sel_reg, 16'h0002);
    chk("coinc_err", sel_err, 0);
    shift_sel(16'h0003);
    chk("sel_0003", sel_reg, 16'h0003);
    chk("multi_err", sel_err, 1);
    clr_mon();
    pulse(1, 1'b1);
    chk("multi_mask_val", mask_val, 16'h0003);
    chk("multi_mask_cnt", mask_cnt, 1);
    for (int i = 0; i < 5; i++) pulse(2, 1'b1);
    gpio_in[2] = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_sel", sel_reg, 0);
    chk("midrst_err", sel_err, 1);
    chk("midrst_outs", {cycle_count, mask_shift_en, mux_shift_en, cfg_sdata}, 0);
    rst_n = 1'b1;
    cyc(8);
    chk("held_hi_sel", sel_reg, 0);
    clr_mon();
    pulse(1, 1'b1);
    chk("zero_sel_no_mask", mask_cnt, 0);
    gpio_in[2] = 1'b0;
    cyc(4);
    chk("fall_no_shift", sel_reg, 0);
    pulse(2, 1'b1);
    chk("rearm_one_shift", sel_reg, 16'h0001);
    chk("rearm_err", sel_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
